// File: rtl/dii_package.sv
// Debug interconnect flit type shared by all DII endpoints.
package dii_package;

  typedef struct packed {
    logic        valid;
    logic        last;
    logic [15:0] data;
  } dii_flit;

endpackage

// File: rtl/osd_event_package.sv
// Event packet header constants and sequencing states shared by event sources.
package osd_event_package;

  localparam logic [1:0] EVENT_TYPE       = 2'b10;
  localparam logic [3:0] SUBTYPE_SAMPLE   = 4'h0;
  localparam logic [3:0] SUBTYPE_OVERFLOW = 4'h5;

  typedef enum logic [2:0] {
    IDLE,
    DEST,
    SRC,
    TYPE,
    PAYLOAD
  } event_state_e;

endpackage

// File: rtl/osd_trace_flit_serializer.sv
// Turns one buffered trace word into a DII event packet: dest, src, type header,
// then the sample payload LS flit first (or a single overflow-count flit).
module osd_trace_flit_serializer
  import dii_package::*;
  import osd_event_package::*;
#(
  parameter int unsigned WIDTH = 34
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [9:0]       id,
  input  logic [15:0]      event_dest,
  input  logic             enable,
  input  logic [WIDTH-1:0] trace_data,
  input  logic             trace_overflow,
  input  logic             trace_valid,
  output logic             trace_ready,
  output dii_flit          debug_out,
  input  logic             debug_out_ready
);

  localparam int unsigned NFLITS = (WIDTH + 15) / 16;
  localparam int unsigned CW     = $clog2(NFLITS + 1);
  localparam int unsigned PADW   = NFLITS * 16;

  event_state_e     state_q, state_d;
  logic [WIDTH-1:0] word_q, word_d;
  logic             ovf_q, ovf_d;
  logic [15:0]      dest_q, dest_d;
  logic [CW-1:0]    idx_q, idx_d;
  dii_flit          flit_d;
  logic             accept;

  // Payload mux: the top flit is zero-extended above WIDTH; overflow uses bits [15:0].
  function automatic logic [15:0] payload_flit(input logic [WIDTH-1:0] word,
                                               input logic ovf,
                                               input logic [CW-1:0] idx);
    logic [PADW-1:0] padded;
    logic [15:0]     r;
    padded = PADW'(word);
    r      = padded[15:0];
    if (!ovf) begin
      for (int k = 0; k < NFLITS; k++) begin
        if (idx == CW'(k)) r = padded[k*16 +: 16];
      end
    end
    return r;
  endfunction

  function automatic logic is_last(input logic ovf, input logic [CW-1:0] idx);
    return ovf || (idx == CW'(NFLITS - 1));
  endfunction

  assign trace_ready = rst_n & enable & (state_q == IDLE);
  assign accept      = trace_valid & trace_ready;

  // Next state plus the flit that state will present; the flit is registered with it.
  always_comb begin
    state_d = state_q;
    word_d  = word_q;
    ovf_d   = ovf_q;
    dest_d  = dest_q;
    idx_d   = idx_q;
    flit_d  = '0;

    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = DEST;
          word_d  = trace_data;
          ovf_d   = trace_overflow;
          dest_d  = event_dest;
        end
      end
      DEST:    if (debug_out_ready) state_d = SRC;
      SRC:     if (debug_out_ready) state_d = TYPE;
      TYPE: begin
        if (debug_out_ready) begin
          state_d = PAYLOAD;
          idx_d   = '0;
        end
      end
      PAYLOAD: begin
        if (debug_out_ready) begin
          if (is_last(ovf_q, idx_q)) state_d = IDLE;
          else                       idx_d   = idx_q + CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    case (state_d)
      DEST: begin
        flit_d.valid = 1'b1;
        flit_d.data  = dest_d;
      end
      SRC: begin
        flit_d.valid = 1'b1;
        flit_d.data  = {6'b0, id};
      end
      TYPE: begin
        flit_d.valid = 1'b1;
        flit_d.data  = {EVENT_TYPE, ovf_d ? SUBTYPE_OVERFLOW : SUBTYPE_SAMPLE, 10'b0};
      end
      PAYLOAD: begin
        flit_d.valid = 1'b1;
        flit_d.last  = is_last(ovf_d, idx_d);
        flit_d.data  = payload_flit(word_d, ovf_d, idx_d);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      word_q    <= '0;
      ovf_q     <= 1'b0;
      dest_q    <= '0;
      idx_q     <= '0;
      debug_out <= '0;
    end else begin
      state_q   <= state_d;
      word_q    <= word_d;
      ovf_q     <= ovf_d;
      dest_q    <= dest_d;
      idx_q     <= idx_d;
      debug_out <= flit_d;
    end
  end

endmodule
